// File: rtl/bool_func_engine.sv
// Programmable Boolean function engine: N_FUNC run-time writable truth tables,
// one-cycle registered evaluation, and a sweep unit for minterm count and equivalence.
module bool_func_engine #(
  parameter int N_IN   = 5,
  parameter int N_FUNC = 4,
  parameter int FSEL_W = (N_FUNC > 1) ? $clog2(N_FUNC) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [FSEL_W-1:0] wr_func,
  input  logic [N_IN-1:0]   wr_addr,
  input  logic              wr_data,
  input  logic              in_valid,
  input  logic [N_IN-1:0]   in_vec,
  output logic              out_valid,
  output logic [N_FUNC-1:0] out_vec,
  input  logic              start,
  input  logic [FSEL_W-1:0] sel_a,
  input  logic [FSEL_W-1:0] sel_b,
  output logic              busy,
  output logic              done,
  output logic [N_IN:0]     count_a,
  output logic              equal,
  output logic [N_IN-1:0]   first_diff
);
  localparam int DEPTH = 2**N_IN;
  localparam logic [N_IN-1:0] IDX_LAST = '1;

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t            state;
  logic [FSEL_W-1:0] lat_a;
  logic [FSEL_W-1:0] lat_b;
  logic [N_IN-1:0]   idx;
  logic [N_IN:0]     cnt_acc;
  logic              eq_acc;
  logic [N_IN-1:0]   diff_acc;

  logic [N_FUNC-1:0] eval_bits;
  logic [N_FUNC-1:0] sweep_bits;
  logic              bit_a;
  logic              bit_b;
  logic              mismatch;
  logic [N_IN:0]     cnt_next;
  logic              eq_next;
  logic [N_IN-1:0]   diff_next;
  logic              wr_ok;

  assign wr_ok = wr_en & ~busy;

  // Out-of-range wr_func matches no channel, so such writes fall away naturally.
  generate
    for (genvar gi = 0; gi < N_FUNC; gi++) begin : g_chan
      logic [DEPTH-1:0] row;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          row <= '0;
        end else if (wr_ok && (32'(wr_func) == gi)) begin
          row[wr_addr] <= wr_data;
        end
      end
      assign eval_bits[gi]  = row[in_vec];
      assign sweep_bits[gi] = row[idx];
    end
  endgenerate

  // A latched selector beyond the last channel reads as constant 0.
  always_comb begin
    bit_a = 1'b0;
    bit_b = 1'b0;
    for (int k = 0; k < N_FUNC; k++) begin
      if (32'(lat_a) == k) bit_a = sweep_bits[k];
      if (32'(lat_b) == k) bit_b = sweep_bits[k];
    end
  end

  assign mismatch  = bit_a ^ bit_b;
  assign cnt_next  = cnt_acc + {{N_IN{1'b0}}, bit_a};
  assign eq_next   = eq_acc & ~mismatch;
  assign diff_next = (eq_acc && mismatch) ? idx : diff_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_vec   <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) out_vec <= eval_bits;
    end
  end

  // Results are loaded from the next-values on the last index so they are valid in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      lat_a      <= '0;
      lat_b      <= '0;
      idx        <= '0;
      cnt_acc    <= '0;
      eq_acc     <= 1'b1;
      diff_acc   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      count_a    <= '0;
      equal      <= 1'b1;
      first_diff <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            lat_a    <= sel_a;
            lat_b    <= sel_b;
            idx      <= '0;
            cnt_acc  <= '0;
            eq_acc   <= 1'b1;
            diff_acc <= '0;
            busy     <= 1'b1;
            state    <= SWEEP;
          end
        end
        SWEEP: begin
          cnt_acc  <= cnt_next;
          eq_acc   <= eq_next;
          diff_acc <= diff_next;
          if (idx == IDX_LAST) begin
            count_a    <= cnt_next;
            equal      <= eq_next;
            first_diff <= diff_next;
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= DONE;
          end else begin
            idx <= idx + N_IN'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bool_func_engine.sv
// Directed bench for bool_func_engine (N_IN=5, N_FUNC=4) with queue-based
// scoreboards for evaluation results and sweep results.
module tb_bool_func_engine;
  localparam int N_IN   = 5;
  localparam int N_FUNC = 4;
  localparam int FSEL_W = 2;
  localparam int DEPTH  = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wr_en = 1'b0;
  logic [FSEL_W-1:0] wr_func = '0;
  logic [N_IN-1:0]   wr_addr = '0;
  logic              wr_data = 1'b0;
  logic              in_valid = 1'b0;
  logic [N_IN-1:0]   in_vec = '0;
  logic              out_valid;
  logic [N_FUNC-1:0] out_vec;
  logic              start = 1'b0;
  logic [FSEL_W-1:0] sel_a = '0;
  logic [FSEL_W-1:0] sel_b = '0;
  logic              busy;
  logic              done;
  logic [N_IN:0]     count_a;
  logic              equal;
  logic [N_IN-1:0]   first_diff;

  typedef struct packed {
    logic [N_IN:0]   cnt;
    logic            eq;
    logic [N_IN-1:0] diff;
  } sweep_t;

  logic [N_FUNC-1:0] exp_eval_q[$];
  sweep_t            exp_sweep_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int busy_cycles = 0;

  always #5 clk = ~clk;

  bool_func_engine #(.N_IN(N_IN), .N_FUNC(N_FUNC), .FSEL_W(FSEL_W)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_func(wr_func), .wr_addr(wr_addr),
    .wr_data(wr_data), .in_valid(in_valid), .in_vec(in_vec), .out_valid(out_valid),
    .out_vec(out_vec), .start(start), .sel_a(sel_a), .sel_b(sel_b), .busy(busy),
    .done(done), .count_a(count_a), .equal(equal), .first_diff(first_diff)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Monitor: pops the scoreboards whenever the DUT presents a result.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cycles = 0;
    end else begin
      if (out_valid) begin
        if (exp_eval_q.size() == 0) begin
          check("eval_unexpected", 32'(out_vec), 32'hDEAD);
        end else begin
          check("eval", 32'(out_vec), 32'(exp_eval_q.pop_front()));
        end
      end
      if (busy) busy_cycles++;
      if (done) begin
        check("sweep_busy_len", 32'(busy_cycles), DEPTH);
        busy_cycles = 0;
        if (exp_sweep_q.size() == 0) begin
          check("sweep_unexpected_done", 32'(count_a), 32'hDEAD);
        end else begin
          sweep_t e;
          e = exp_sweep_q.pop_front();
          check("sweep_count", 32'(count_a), 32'(e.cnt));
          check("sweep_equal", 32'(equal), 32'(e.eq));
          check("sweep_diff", 32'(first_diff), 32'(e.diff));
        end
      end
    end
  end

  task automatic write_bit(input int f, input int a, input logic d);
    wr_en = 1'b1; wr_func = FSEL_W'(f); wr_addr = N_IN'(a); wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic eval(input int v, input logic [N_FUNC-1:0] expv);
    in_valid = 1'b1; in_vec = N_IN'(v);
    exp_eval_q.push_back(expv);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (!done && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!done) check("sweep_timeout", 32'(t), 32'hFFFF);
    @(negedge clk);
  endtask

  task automatic sweep(input int a, input int b, input int cnt, input logic eq, input int diff);
    sweep_t e;
    e.cnt = (N_IN + 1)'(cnt); e.eq = eq; e.diff = N_IN'(diff);
    start = 1'b1; sel_a = FSEL_W'(a); sel_b = FSEL_W'(b);
    exp_sweep_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    wait_done();
  endtask

  initial begin
    int k;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_vec", 32'(out_vec), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_count_a", 32'(count_a), 0);
    check("rst_equal", 32'(equal), 1);
    check("rst_first_diff", 32'(first_diff), 0);
    rst_n = 1'b1;
    @(negedge clk);

    eval(5'b10101, 4'h0);
    sweep(0, 1, 0, 1'b1, 0);

    // ch0 = A~BC + ~AB~C + ABC and ch1 = ~AB~C + AC, both minterms {2,5,7}
    write_bit(0, 2, 1'b1); write_bit(0, 5, 1'b1); write_bit(0, 7, 1'b1);
    write_bit(1, 2, 1'b1); write_bit(1, 5, 1'b1); write_bit(1, 7, 1'b1);
    eval(5'b00101, 4'b0011);
    eval(5'b00011, 4'b0000);
    eval(5'b00010, 4'b0011);
    eval(5'b00111, 4'b0011);

    // Same-cycle write and evaluate of ch2[5] returns the old value.
    wr_en = 1'b1; wr_func = 2'd2; wr_addr = 5'd5; wr_data = 1'b1;
    in_valid = 1'b1; in_vec = 5'd5; exp_eval_q.push_back(4'b0011);
    @(negedge clk);
    wr_en = 1'b0; in_valid = 1'b0;
    eval(5'b00101, 4'b0111);

    sweep(0, 1, 3, 1'b1, 0);

    write_bit(1, 4, 1'b1); write_bit(1, 6, 1'b1);
    sweep(0, 1, 3, 1'b0, 4);
    sweep(1, 0, 5, 1'b0, 4);
    sweep(1, 1, 5, 1'b1, 0);

    for (int i = 0; i < DEPTH; i++) write_bit(2, i, 1'b1);
    sweep(2, 3, 32, 1'b0, 0);
    sweep(3, 0, 0, 1'b0, 2);

    // Write, start and evaluation while busy: write dropped, start ignored.
    begin
      sweep_t e;
      e.cnt = 6'd3; e.eq = 1'b0; e.diff = 5'd4;
      start = 1'b1; sel_a = 2'd0; sel_b = 2'd1; exp_sweep_q.push_back(e);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      wr_en = 1'b1; wr_func = 2'd0; wr_addr = 5'd0; wr_data = 1'b1;
      start = 1'b1; sel_a = 2'd2; sel_b = 2'd2;
      in_valid = 1'b1; in_vec = 5'd0; exp_eval_q.push_back(4'b0100);
      @(negedge clk);
      wr_en = 1'b0; start = 1'b0; in_valid = 1'b0;
      wait_done();
    end
    eval(5'b00000, 4'b0100);
    sweep(0, 1, 3, 1'b0, 4);

    // Reset on the fourth busy cycle aborts the sweep.
    start = 1'b1; sel_a = 2'd2; sel_b = 2'd3;
    @(negedge clk);
    start = 1'b0;
    k = 1;
    while (k < 4) begin
      @(negedge clk);
      k++;
    end
    check("pre_rst_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_done", 32'(done), 0);
    check("midrst_equal", 32'(equal), 1);
    check("midrst_count_a", 32'(count_a), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    eval(5'b00000, 4'b0000);
    eval(5'b00101, 4'b0000);
    eval(5'b11111, 4'b0000);
    sweep(2, 0, 0, 1'b1, 0);

    repeat (3) @(negedge clk);
    check("eval_queue_drained", 32'(exp_eval_q.size()), 0);
    check("sweep_queue_drained", 32'(exp_sweep_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
